// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array's PE accumulators on compute_done and streams them out one word per beat.
// Optional build macro DRAIN_ROW_MAJOR_EN selects row-major stream order; the default order is column-major.
module systolic_result_drain #(
  parameter int out_word_size = 24,
  parameter int num_row       = 4,
  parameter int num_col       = 2,
  localparam int N            = num_row * num_col,
  localparam int IW           = (N > 1) ? $clog2(N) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     compute_done,
  input  logic [0:N*out_word_size-1] pe_register_vals,
  input  logic [out_word_size-1:0] cycles_count,
  output logic [out_word_size-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [IW-1:0]            out_index,
  output logic                     busy,
  output logic                     drain_done,
  output logic                     overflow,
  output logic [out_word_size-1:0] tile_cycles
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  localparam logic [IW-1:0] K_LAST = IW'(N - 1);

  state_t                   state_q, state_d;
  logic [IW-1:0]            k_q, k_d;
  logic                     done_d;
  logic [out_word_size-1:0] snap_q [N];
  logic                     start;
  logic [IW-1:0]            sel;

  // Maps stream position k to the PE whose word goes out at that position.
  function automatic int pe_of(input int k);
`ifdef DRAIN_ROW_MAJOR_EN
    return k;
`else
    return (k % num_row) * num_col + (k / num_row);
`endif
  endfunction

  assign start = compute_done & ~done_d;
  assign sel   = IW'(pe_of(int'(k_q)));

  // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_index  = '0;
    out_data   = '0;
    busy       = 1'b0;
    drain_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          k_d     = '0;
        end
      end
      STREAM: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_index = k_q;
        out_data  = snap_q[sel];
        out_last  = (k_q == K_LAST);
        if (out_ready) begin
          if (k_q == K_LAST) state_d = DONE;
          else               k_d     = k_q + 1'b1;
        end
      end
      DONE: begin
        drain_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      done_d      <= 1'b0;
      overflow    <= 1'b0;
      tile_cycles <= '0;
      // NOTE: the snapshot buffer is reset too, so a stream can never expose stale data from before reset.
      for (int p = 0; p < N; p++) snap_q[p] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      done_d  <= compute_done;
      if (start) begin
        if (state_q == IDLE) begin
          tile_cycles <= cycles_count;
          for (int p = 0; p < N; p++)
            snap_q[p] <= pe_register_vals[p*out_word_size +: out_word_size];
        end else begin
          // A tile arriving while the previous one is still draining is dropped.
          overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
Output-side stage that sits directly downstream of the systolic array. It snapshots the array's flattened PE accumulator bus when the array reports compute_done. It then streams the num_row*num_col results one word per beat over a valid/ready interface, in column-major order (the order the results file is written). It frees the array for the next tile as soon as the snapshot is taken.

Parameters:
out_word_size, 24, width of one PE accumulator / output word
num_row, 4, PE rows of the array
num_col, 2, PE columns of the array

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
compute_done  input  1  level from array; high while results are final
pe_register_vals  input  out_word_size*num_row*num_col  flattened PE bus, declared [0:N*W-1]; PE p=row*num_col+col occupies bits p*W .. (p+1)*W-1
cycles_count  input  out_word_size  array cycle counter
out_data  output  out_word_size  current result word
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts the word
out_last  output  1  high with the final word of a tile
out_index  output  $clog2(num_row*num_col) (min 1)  stream position k of out_data
busy  output  1  snapshot held, stream not finished
drain_done  output  1  one-cycle pulse after the last word is accepted
overflow  output  1  sticky; a tile was dropped
tile_cycles  output  out_word_size  cycles_count captured with the snapshot

Behaviour:
- N = num_row*num_col. Reset (reset=0, asynchronous) clears every output, the snapshot buffer, the state, and done_d (the registered previous compute_done) to 0.
- Trigger: start = compute_done & ~done_d. It is edge-detected because compute_done stays high for many cycles.
- FSM states are IDLE, STREAM and DONE.
- IDLE: on start, copy all N words into the snapshot buffer, latch tile_cycles=cycles_count, set k=0 and go to STREAM. busy and out_valid go high on the next cycle (1-cycle latency from the start edge).
- Stream order is column-major: k -> col=k/num_row, row=k%num_row, PE=row*num_col+col. out_data=buf[PE(k)] and out_index=k.
- STREAM: out_valid=1. On out_valid&out_ready: if k<N-1, k<=k+1; if k=N-1, go to DONE.
- STREAM while out_ready=0: out_data, out_index and out_last hold stable.
- out_last = (k==N-1) while in STREAM.
- DONE lasts exactly one cycle: drain_done=1, out_valid=0, busy=0, then back to IDLE.
- start while in STREAM or DONE: the tile is ignored, overflow<=1 (sticky until reset) and the snapshot is unchanged.
- A start in the same cycle that DONE returns to IDLE is also flagged as overflow. A tile is accepted only when the FSM is in IDLE at the start edge.
- compute_done held high continuously produces no new start.
- Reset asserted mid-stream aborts immediately: out_valid=0 and nothing is replayed after release.
- N=1: out_last is high on the first beat.
- The block performs no arithmetic; words pass bit-exact.

Optional Feature:
DRAIN_ROW_MAJOR_EN: when defined, the stream order is row-major (PE(k)=k) and out_last/out_index keep the same meaning. When undefined, the order is column-major as above. Port list is identical in both builds.

Test Plan:
- Reset then load. PE p=0x000010+p (4x2), compute_done rises at cycle T, out_ready=1. Expected: out_valid from T+1; data 0x10,0x12,0x14,0x16,0x11,0x13,0x15,0x17; out_last on the 8th beat; drain_done one cycle later. With DRAIN_ROW_MAJOR_EN, data is 0x10..0x17 in order.
- Backpressure: out_ready toggles 1,0,0,1. Expected: each word held stable while not ready, no word skipped or duplicated, 8 beats total.
- Snapshot isolation: change pe_register_vals to 0xFFFFFF after the start edge. Expected: the stream still outputs the original values; tile_cycles equals the cycles_count sampled at start (e.g. 0x000014).
- Level hold and overflow: hold compute_done high for 30 cycles. Expected: exactly one tile, overflow=0. Then drop compute_done and re-raise it mid-stream. Expected: overflow=1, the current stream completes unchanged, no second tile.
- Async reset: pull reset low at beat 3. Expected: out_valid=0 immediately, overflow=0, busy=0. After release with no new edge, out_valid stays 0.
- Back-to-back tiles: a second start arrives 2 cycles after drain_done. Expected: accepted, 8 new beats, overflow stays 0.
